alu_iterativa: RTL and testbench

Parametrised multi-cycle ALU, the successor to the combinational 64-bit ALU. It keeps the same 4-bit operation encoding and `zero` flag, and adds signed compare, overflow detection, and iterative unsigned multiply, divide and remainder. Operands are accepted and results delivered through valid/ready handshakes. It sits in the execute stage, which stalls on `in_ready`/`out_valid`.

---
 rtl/alu_iterativa.sv | 203 ++++++++++++++++++++
 tb/tb_alu_iterativa.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iterativa.sv
// Multi-cycle ALU: logic/add/sub/compare complete in one cycle; MUL, DIVU and REMU
// iterate one bit per cycle (shift-add / restoring division) behind valid/ready handshakes.
module alu_iterativa #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero,
    output logic             illegal_op
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_DIVU = 4'b1001,
        OP_REMU = 4'b1010,
        OP_NOR  = 4'b1100
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] rem;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic [WIDTH-1:0] quick_res;
    logic             quick_ovf;
    logic             quick_dz;
    logic             is_legal;
    logic             is_iter;

    always_comb begin
        sum       = a + b;
        diff      = a - b;
        slt       = ($signed(a) < $signed(b));
        quick_res = '0;
        quick_ovf = 1'b0;
        quick_dz  = 1'b0;
        is_legal  = 1'b1;
        is_iter   = 1'b0;
        case (alu_op)
            OP_AND: quick_res = a & b;
            OP_OR:  quick_res = a | b;
            OP_NOR: quick_res = ~(a | b);
            OP_ADD: begin
                quick_res = sum;
                quick_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                quick_res = diff;
                quick_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: quick_res = {{(WIDTH-1){1'b0}}, slt};
            OP_MUL: is_iter = 1'b1;
            OP_DIVU: begin
                if (b == '0) begin
                    quick_res = '1;
                    quick_dz  = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
            OP_REMU: begin
                if (b == '0) begin
                    quick_res = a;
                    quick_dz  = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
            default: is_legal = 1'b0;
        endcase
    end

    // MUL: opa is the left-shifting multiplicand, opb the right-shifting multiplier.
    // DIVU/REMU: opa shifts the dividend out MSB first and the quotient in LSB first.
    logic [WIDTH-1:0] mul_next;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] iter_res;

    always_comb begin
        mul_next  = opb[0] ? (acc + opa) : acc;
        rem_shift = {rem, opa[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, opb});
        // The true difference is below the divisor, so WIDTH bits hold it exactly.
        rem_next  = rem_ge ? (rem_shift[WIDTH-1:0] - opb) : rem_shift[WIDTH-1:0];
        quo_next  = {opa[WIDTH-2:0], rem_ge};
        if (op_r == OP_MUL) begin
            iter_res = mul_next;
        end else if (op_r == OP_DIVU) begin
            iter_res = quo_next;
        end else begin
            iter_res = rem_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_r       <= OP_AND;
            acc        <= '0;
            opa        <= '0;
            opb        <= '0;
            rem        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            result     <= '0;
            zero       <= 1'b1;
            overflow   <= 1'b0;
            div_zero   <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        op_r     <= alu_op;
                        acc      <= '0;
                        rem      <= '0;
                        opa      <= a;
                        opb      <= b;
                        if (is_iter) begin
                            state <= BUSY;
                            cnt   <= CNT_W'(WIDTH);
                        end else begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            result     <= quick_res;
                            zero       <= (quick_res == '0);
                            overflow   <= quick_ovf;
                            div_zero   <= quick_dz;
                            illegal_op <= !is_legal;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (op_r == OP_MUL) begin
                        acc <= mul_next;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end else begin
                        opa <= quo_next;
                        rem <= rem_next;
                    end
                    if (cnt == CNT_W'(1)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        result     <= iter_res;
                        zero       <= (iter_res == '0);
                        overflow   <= 1'b0;
                        div_zero   <= 1'b0;
                        illegal_op <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iterativa.sv
// Bench for alu_iterativa: WIDTH=8 and WIDTH=64 instances checked against an arithmetic
// reference model with directed and randomized operations.
module tb_alu_iterativa;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_MUL  = 4'b1000;
    localparam logic [3:0] C_DIVU = 4'b1001;
    localparam logic [3:0] C_REMU = 4'b1010;
    localparam logic [3:0] C_NOR  = 4'b1100;

    logic        clk;
    logic        rst_n;
    logic        in_valid8, in_valid64, out_ready;
    logic [63:0] a, b;
    logic [3:0]  op;

    logic        in_ready8, out_valid8, zero8, ovf8, dz8, ill8;
    logic [7:0]  result8;
    logic        in_ready64, out_valid64, zero64, ovf64, dz64, ill64;
    logic [63:0] result64;

    logic        sel64;
    logic        o_rdy, o_vld;
    logic [63:0] o_res;
    logic [3:0]  o_flags;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_res;
    logic [3:0]  last_flags;

    typedef struct packed {
        logic [63:0] res;
        logic        zero;
        logic        ovf;
        logic        dz;
        logic        ill;
    } exp_t;

    alu_iterativa #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a[7:0]), .b(b[7:0]), .alu_op(op), .out_valid(out_valid8), .out_ready(out_ready),
        .result(result8), .zero(zero8), .overflow(ovf8), .div_zero(dz8), .illegal_op(ill8)
    );

    alu_iterativa #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a), .b(b), .alu_op(op), .out_valid(out_valid64), .out_ready(out_ready),
        .result(result64), .zero(zero64), .overflow(ovf64), .div_zero(dz64), .illegal_op(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (sel64) begin
            o_rdy   = in_ready64;
            o_vld   = out_valid64;
            o_res   = result64;
            o_flags = {zero64, ovf64, dz64, ill64};
        end else begin
            o_rdy   = in_ready8;
            o_vld   = out_valid8;
            o_res   = {56'd0, result8};
            o_flags = {zero8, ovf8, dz8, ill8};
        end
    end

    function automatic exp_t model(input int w, input logic [3:0] opc,
                                   input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mask, sx, sy, r;
        exp_t e;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        sx = x[w-1] ? (x | ~mask) : x;
        sy = y[w-1] ? (y | ~mask) : y;
        e = '0;
        r = '0;
        case (opc)
            C_AND: r = x & y;
            C_OR:  r = x | y;
            C_NOR: r = ~(x | y) & mask;
            C_ADD: begin
                r = (x + y) & mask;
                e.ovf = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
            end
            C_SUB: begin
                r = (x - y) & mask;
                e.ovf = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
            end
            C_SLT: r = ($signed(sx) < $signed(sy)) ? 64'd1 : 64'd0;
            C_MUL: r = (x * y) & mask;
            C_DIVU: begin
                if (y == 0) begin r = mask; e.dz = 1'b1; end
                else r = x / y;
            end
            C_REMU: begin
                if (y == 0) begin r = x; e.dz = 1'b1; end
                else r = x % y;
            end
            default: e.ill = 1'b1;
        endcase
        e.res  = r;
        e.zero = (r == 0);
        return e;
    endfunction

    // One full transaction on the selected instance, with `hold` cycles of out_ready low.
    task automatic run_op(input int w, input logic [3:0] opc, input logic [63:0] xi,
                          input logic [63:0] yi, input int hold, input string tag);
        exp_t        e;
        int          lat, n, exp_lat;
        logic [63:0] x, y, r0;
        logic [3:0]  f0;
        x = (w == 64) ? xi : (xi & 64'hFF);
        y = (w == 64) ? yi : (yi & 64'hFF);
        e = model(w, opc, x, y);
        exp_lat = ((opc == C_MUL) || ((opc == C_DIVU || opc == C_REMU) && y != 0)) ? w + 1 : 1;
        sel64 = (w == 64);
        out_ready = 1'b0;
        @(negedge clk);
        n = 0;
        while (!o_rdy && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (!o_rdy) begin
            errors++;
            $display("FAIL %s ready_timeout: in_ready=%b required 1", tag, o_rdy);
            return;
        end
        a = x; b = y; op = opc;
        if (w == 64) in_valid64 = 1'b1; else in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; in_valid64 = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 4'($urandom);
        lat = 1;
        while (!o_vld && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", tag, lat, exp_lat);
        end
        checks++;
        if (o_res !== e.res) begin
            errors++;
            $display("FAIL %s result: got %h required %h", tag, o_res, e.res);
        end
        checks++;
        if (o_flags !== {e.zero, e.ovf, e.dz, e.ill}) begin
            errors++;
            $display("FAIL %s flags(z,ov,dz,ill): got %b required %b", tag, o_flags,
                     {e.zero, e.ovf, e.dz, e.ill});
        end
        checks++;
        if (o_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_done: got %b required 0", tag, o_rdy);
        end
        r0 = o_res; f0 = o_flags;
        last_res = o_res; last_flags = o_flags;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if (w == 64) in_valid64 = 1'b1; else in_valid8 = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (o_res !== r0 || o_flags !== f0 || o_vld !== 1'b1 || o_rdy !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: res=%h flags=%b vld=%b rdy=%b required res=%h flags=%b vld=1 rdy=0",
                         tag, i, o_res, o_flags, o_vld, o_rdy, r0, f0);
            end
        end
        @(negedge clk);
        in_valid8 = 1'b0; in_valid64 = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (o_vld !== 1'b0 || o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s release: vld=%b rdy=%b required vld=0 rdy=1", tag, o_vld, o_rdy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid8 = 1'b0; in_valid64 = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0; sel64 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid8, result8, zero8, ovf8, dz8, ill8} !== {1'b0, 8'd0, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL reset8: vld=%b res=%h z=%b ov=%b dz=%b ill=%b required 0 00 1 0 0 0",
                     out_valid8, result8, zero8, ovf8, dz8, ill8);
        end
        checks++;
        if ({out_valid64, result64, zero64, ovf64, dz64, ill64} !== {1'b0, 64'd0, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL reset64: vld=%b res=%h z=%b ov=%b dz=%b ill=%b required 0 0 1 0 0 0",
                     out_valid64, result64, zero64, ovf64, dz64, ill64);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready8 !== 1'b1 || in_ready64 !== 1'b1 || out_valid8 !== 1'b0 || out_valid64 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy8=%b rdy64=%b vld8=%b vld64=%b required 1 1 0 0",
                     in_ready8, in_ready64, out_valid8, out_valid64);
        end
    endtask

    task automatic test_basic64;
        run_op(64, C_ADD, 64'd5, 64'd7, 0, "add64");
        checks++;
        if (last_res !== 64'd12 || last_flags[3:2] !== 2'b00) begin
            errors++;
            $display("FAIL add64_const: res=%0d z,ov=%b required 12 00", last_res, last_flags[3:2]);
        end
        run_op(64, C_SUB, 64'd9, 64'd9, 0, "sub64");
        checks++;
        if (last_res !== 64'd0 || last_flags[3] !== 1'b1) begin
            errors++;
            $display("FAIL sub64_const: res=%0d z=%b required 0 1", last_res, last_flags[3]);
        end
    endtask

    task automatic test_overflow;
        run_op(8, C_ADD, 64'h7F, 64'h01, 0, "add_ovf");
        checks++;
        if (last_res !== 64'h80 || last_flags[2] !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf_const: res=%h ov=%b required 80 1", last_res, last_flags[2]);
        end
        run_op(8, C_SUB, 64'h80, 64'h01, 0, "sub_ovf");
        checks++;
        if (last_res !== 64'h7F || last_flags[2] !== 1'b1) begin
            errors++;
            $display("FAIL sub_ovf_const: res=%h ov=%b required 7f 1", last_res, last_flags[2]);
        end
        run_op(8, C_SLT, 64'hFF, 64'h01, 0, "slt");
        checks++;
        if (last_res !== 64'd1) begin
            errors++;
            $display("FAIL slt_const: res=%h required 1", last_res);
        end
    endtask

    task automatic test_mul;
        run_op(8, C_MUL, 64'd13, 64'd11, 0, "mul_13x11");
        checks++;
        if (last_res !== 64'h8F) begin
            errors++;
            $display("FAIL mul_const1: res=%h required 8f", last_res);
        end
        run_op(8, C_MUL, 64'hFF, 64'h02, 0, "mul_ffx2");
        checks++;
        if (last_res !== 64'hFE) begin
            errors++;
            $display("FAIL mul_const2: res=%h required fe", last_res);
        end
    endtask

    task automatic test_div;
        run_op(8, C_DIVU, 64'd100, 64'd7, 0, "divu");
        checks++;
        if (last_res !== 64'd14) begin
            errors++;
            $display("FAIL divu_const: res=%0d required 14", last_res);
        end
        run_op(8, C_REMU, 64'd100, 64'd7, 0, "remu");
        checks++;
        if (last_res !== 64'd2) begin
            errors++;
            $display("FAIL remu_const: res=%0d required 2", last_res);
        end
        run_op(8, C_DIVU, 64'd100, 64'd0, 0, "divu_by0");
        checks++;
        if (last_res !== 64'hFF || last_flags[1] !== 1'b1) begin
            errors++;
            $display("FAIL divu_by0_const: res=%h dz=%b required ff 1", last_res, last_flags[1]);
        end
        run_op(8, C_REMU, 64'd100, 64'd0, 0, "remu_by0");
        checks++;
        if (last_res !== 64'd100 || last_flags[1] !== 1'b1) begin
            errors++;
            $display("FAIL remu_by0_const: res=%0d dz=%b required 100 1", last_res, last_flags[1]);
        end
    endtask

    task automatic test_handshake_illegal;
        run_op(8, C_OR, 64'h0F, 64'hF0, 5, "hold5");
        run_op(8, 4'b0011, 64'h55, 64'hAA, 2, "illegal");
        checks++;
        if (last_res !== 64'd0 || last_flags !== 4'b1001) begin
            errors++;
            $display("FAIL illegal_const: res=%h flags=%b required 0 1001", last_res, last_flags);
        end
    endtask

    task automatic b2b(input logic [3:0] opc, input logic [63:0] x, input logic [63:0] y,
                       input int gap, input int cycles, input string tag);
        exp_t e;
        int   last, n;
        e = model(8, opc, x, y);
        sel64 = 1'b0;
        @(negedge clk);
        a = x; b = y; op = opc; out_ready = 1'b1; in_valid8 = 1'b1;
        last = -1; n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (o_vld) begin
                checks++;
                if (o_res !== e.res) begin
                    errors++;
                    $display("FAIL %s result: got %h required %h", tag, o_res, e.res);
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last != gap) begin
                        errors++;
                        $display("FAIL %s spacing: got %0d required %0d", tag, c - last, gap);
                    end
                end
                last = c;
                n++;
            end
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        for (int k = 0; k < 50 && !(o_rdy && !o_vld); k++) @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (n < 3 || !o_rdy) begin
            errors++;
            $display("FAIL %s stream: got %0d results rdy=%b required >=3 rdy=1", tag, n, o_rdy);
        end
    endtask

    task automatic test_back_to_back;
        b2b(C_ADD, 64'd3, 64'd4, 2, 20, "b2b_add");
        b2b(C_MUL, 64'd3, 64'd5, 10, 45, "b2b_mul");
    endtask

    task automatic test_random;
        logic [3:0] codes [10];
        logic [3:0] opc;
        logic [63:0] x, y;
        codes = '{C_AND, C_OR, C_ADD, C_SUB, C_NOR, C_SLT, C_MUL, C_DIVU, C_REMU, 4'b1111};
        for (int i = 0; i < 120; i++) begin
            opc = codes[$urandom_range(0, 9)];
            if (opc == 4'b1111) opc = 4'($urandom);
            x = {$urandom, $urandom};
            y = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            run_op(8, opc, x, y, $urandom_range(0, 2), "rand8");
        end
        for (int i = 0; i < 30; i++) begin
            opc = codes[$urandom_range(0, 9)];
            if (opc == 4'b1111) opc = 4'($urandom);
            x = {$urandom, $urandom};
            y = ($urandom_range(0, 5) == 0) ? 64'd0 : {32'($urandom_range(0, 3)) * $urandom, $urandom};
            run_op(64, opc, x, y, $urandom_range(0, 1), "rand64");
        end
    endtask

    task automatic test_reset_busy;
        int stray;
        sel64 = 1'b1;
        @(negedge clk);
        a = 64'hDEAD_BEEF_1234_5678; b = 64'h0000_0000_0F0F_0F0F; op = C_MUL;
        out_ready = 1'b1; in_valid64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (out_valid64 !== 1'b0 || in_ready64 !== 1'b0) begin
            errors++;
            $display("FAIL busy_before_reset: vld=%b rdy=%b required 0 0", out_valid64, in_ready64);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready64, out_valid64, result64, zero64, ovf64, dz64, ill64} !==
            {1'b1, 1'b0, 64'd0, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL reset_busy: rdy=%b vld=%b res=%h z=%b ov=%b dz=%b ill=%b required 1 0 0 1 0 0 0",
                     in_ready64, out_valid64, result64, zero64, ovf64, dz64, ill64);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (out_valid64) stray++;
        end
        out_ready = 1'b0;
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_busy_stray: out_valid cycles=%0d required 0", stray);
        end
        run_op(64, C_ADD, 64'd1000, 64'd2345, 0, "add_after_reset");
        checks++;
        if (last_res !== 64'd3345) begin
            errors++;
            $display("FAIL add_after_reset_const: res=%0d required 3345", last_res);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic64();
        test_overflow();
        test_mul();
        test_div();
        test_handshake_illegal();
        test_back_to_back();
        test_random();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
